// File: rtl/matmul_result_drain.sv
// matmul_result_drain: drains the 3x3 MAC array results.
// A capture strobe snapshots all DIM*DIM accumulator words, then they are
// streamed out row-major, cropped to the active rows x cols, one word per
// valid/ready handshake.
// Optional feature macro: RESULT_CHKSUM_EN appends one checksum word
// (wrap-around sum of the emitted words) after the last result word.
//
// Handshake: a word transfers at a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_data and
// out_last are held stable. out_valid never depends on out_ready.
module matmul_result_drain #(
    parameter int ACC_W = 10,
    parameter int DIM   = 3
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     capture,
    input  logic [1:0]               r_rows,
    input  logic [1:0]               r_cols,
    input  logic [ACC_W*DIM*DIM-1:0] res_in,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     dim_err,
    output logic                     drop_err,
    output logic [1:0]               dbg_state
);

    localparam int NW = DIM * DIM;
    localparam int SW = ACC_W * NW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef RESULT_CHKSUM_EN
        S_STREAM = 2'd1,
        S_CHK    = 2'd2
`else
        S_STREAM = 2'd1
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      snap_q, snap_d;
    logic [1:0]         rows_q, rows_d;
    logic [1:0]         cols_q, cols_d;
    logic [1:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;
    logic               dim_err_q, dim_err_d;
    logic               drop_err_q, drop_err_d;
`ifdef RESULT_CHKSUM_EN
    logic [ACC_W-1:0]   chk_q, chk_d;
`endif

    logic hs;
    logic dims_ok;
    logic at_final;
    logic cap_open;
    logic accept;

    // Select word (r,c) of a flattened snapshot; constant part-selects only.
    function automatic logic [ACC_W-1:0] pick_word(input logic [SW-1:0] s,
                                                   input logic [1:0]    r,
                                                   input logic [1:0]    c);
        int               idx;
        logic [ACC_W-1:0] w;
        idx = int'(r) * DIM + int'(c);
        w   = '0;
        for (int k = 0; k < NW; k++) begin
            if (k == idx) begin
                w = s[k*ACC_W +: ACC_W];
            end
        end
        return w;
    endfunction

    // Next-state, counter, snapshot and registered-output computation.
    always_comb begin
        hs       = out_valid_q & out_ready;
        dims_ok  = (r_rows != 2'd0) && (r_cols != 2'd0);
        at_final = (row_q == rows_q - 2'd1) && (col_q == cols_q - 2'd1);
        cap_open = 1'b0;
        accept   = 1'b0;

        state_d    = state_q;
        snap_d     = snap_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        col_d      = col_q;
        dim_err_d  = 1'b0;
        drop_err_d = 1'b0;
`ifdef RESULT_CHKSUM_EN
        chk_d      = chk_q;
`endif

        case (state_q)
            S_IDLE: begin
                cap_open = 1'b1;
            end
            S_STREAM: begin
                if (hs) begin
`ifdef RESULT_CHKSUM_EN
                    chk_d = chk_q + out_data_q;
`endif
                    if (at_final) begin
`ifdef RESULT_CHKSUM_EN
                        // Result words done; the checksum word follows.
                        state_d = S_CHK;
`else
                        // Burst done; a capture this same cycle restarts with no bubble.
                        state_d  = S_IDLE;
                        cap_open = 1'b1;
`endif
                    end else if (col_q == cols_q - 2'd1) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
`ifdef RESULT_CHKSUM_EN
            S_CHK: begin
                if (hs) begin
                    state_d  = S_IDLE;
                    cap_open = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A capture is taken only when the block is (or is just becoming) free.
        if (capture) begin
            if (!cap_open) begin
                drop_err_d = 1'b1;
            end else if (dims_ok) begin
                accept = 1'b1;
            end else begin
                dim_err_d = 1'b1;
            end
        end

        if (accept) begin
            state_d = S_STREAM;
            snap_d  = res_in;
            rows_d  = r_rows;
            cols_d  = r_cols;
            row_d   = 2'd0;
            col_d   = 2'd0;
`ifdef RESULT_CHKSUM_EN
            chk_d   = '0;
`endif
        end

        // Outputs are derived from the next state so they are registered.
        out_valid_d = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        out_data_d  = '0;
        out_last_d  = 1'b0;
        if (state_d == S_STREAM) begin
            out_data_d = pick_word(snap_d, row_d, col_d);
`ifndef RESULT_CHKSUM_EN
            out_last_d = (row_d == rows_d - 2'd1) && (col_d == cols_d - 2'd1);
`endif
        end
`ifdef RESULT_CHKSUM_EN
        if (state_d == S_CHK) begin
            out_data_d = chk_d;
            out_last_d = 1'b1;
        end
`endif
    end

    // State and output registers; clear aborts everything immediately.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            snap_q      <= '0;
            rows_q      <= 2'd0;
            cols_q      <= 2'd0;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            dim_err_q   <= 1'b0;
            drop_err_q  <= 1'b0;
`ifdef RESULT_CHKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            dim_err_q   <= dim_err_d;
            drop_err_q  <= drop_err_d;
`ifdef RESULT_CHKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign dim_err   = dim_err_q;
    assign drop_err  = drop_err_q;
    assign dbg_state = state_q;

endmodule
